// File: rtl/multimac_sequencer.sv
// Job controller for the multimac core: round-robin grant, core reset/init,
// item streaming, fixed-budget run, result capture. Optional MMSEQ_TIMEOUT_EN adds LOAD idle abort + res_err.
module multimac_sequencer #(
  parameter int RUN_CYCLES   = 18,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_op,
  output logic [1:0]  req_ready,
  input  logic [1:0]  item_valid,
  input  logic [7:0]  item_index,
  input  logic [7:0]  item_data,
  input  logic [1:0]  item_last,
  output logic [1:0]  item_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [12:0] res_data,
  output logic        res_id,
`ifdef MMSEQ_TIMEOUT_EN
  output logic        res_err,
`endif
  output logic        busy,
  output logic        core_rst_n,
  output logic [1:0]  core_insn,
  output logic        core_load,
  output logic        core_run,
  output logic [3:0]  core_index,
  output logic [3:0]  core_data,
  input  logic [12:0] core_out
);

  typedef enum logic [2:0] {IDLE, CRST, INIT, LOAD, RUN, CAPT, RESP} state_t;

  localparam logic [7:0] RUN_LAST = 8'(RUN_CYCLES - 1);

  if (RUN_CYCLES < 1 || RUN_CYCLES > 255 || LOAD_TIMEOUT < 1 || LOAD_TIMEOUT > 255) begin : g_param_chk
    $error("multimac_sequencer: RUN_CYCLES/LOAD_TIMEOUT out of range 1..255");
  end

  state_t     state, nstate;
  logic       gid, rr_last, ngid;
  logic [1:0] op, nop;
  logic [7:0] run_cnt;
  logic       take, accept, last_acc;

`ifdef MMSEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);
  logic [7:0] idle_cnt;
  logic       tmo;
  assign tmo = (state == LOAD) && !accept && (idle_cnt == TMO_LAST);
`endif

  // On a tie the requester that did not win last time gets the grant.
  assign ngid     = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
  assign nop      = ngid ? req_op[3:2] : req_op[1:0];
  assign take     = (state == IDLE) && (|req_valid);
  assign accept   = (state == LOAD) && item_valid[gid];
  assign last_acc = accept && item_last[gid];

  assign item_ready = (state == LOAD) ? (gid ? 2'b10 : 2'b01) : 2'b00;
  assign core_load  = accept;
  assign core_index = (state == LOAD) ? (gid ? item_index[7:4] : item_index[3:0]) : 4'd0;
  assign core_data  = (state == LOAD) ? (gid ? item_data[7:4]  : item_data[3:0])  : 4'd0;

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (take) nstate = (nop == 2'b11) ? RESP : CRST;
      CRST: nstate = INIT;
      INIT: nstate = LOAD;
      LOAD: begin
        if (last_acc) nstate = RUN;
`ifdef MMSEQ_TIMEOUT_EN
        else if (tmo) nstate = RESP;
`endif
      end
      RUN:  if (run_cnt == RUN_LAST) nstate = CAPT;
      CAPT: nstate = RESP;
      RESP: if (res_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Status/core controls are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      gid        <= 1'b0;
      op         <= 2'b00;
      run_cnt    <= 8'd0;
      req_ready  <= 2'b00;
      res_valid  <= 1'b0;
      res_data   <= 13'd0;
      res_id     <= 1'b0;
      busy       <= 1'b0;
      core_rst_n <= 1'b0;
      core_insn  <= 2'b00;
      core_run   <= 1'b0;
`ifdef MMSEQ_TIMEOUT_EN
      idle_cnt   <= 8'd0;
      res_err    <= 1'b0;
`endif
    end else begin
      state      <= nstate;
      req_ready  <= 2'b00;
      busy       <= (nstate != IDLE);
      core_rst_n <= (nstate != CRST);
      core_run   <= (nstate == RUN);
      res_valid  <= (nstate == RESP);
      core_insn  <= (nstate inside {INIT, LOAD, RUN, CAPT}) ? op : 2'b00;
      run_cnt    <= (state == RUN) ? run_cnt + 8'd1 : 8'd0;
      if (take) begin
        gid       <= ngid;
        op        <= nop;
        rr_last   <= ngid;
        req_ready <= ngid ? 2'b10 : 2'b01;
        res_id    <= ngid;
        res_data  <= 13'd0;
`ifdef MMSEQ_TIMEOUT_EN
        res_err   <= 1'b0;
`endif
      end
      if (state == CAPT) begin
        res_data <= core_out;
        res_id   <= gid;
      end
`ifdef MMSEQ_TIMEOUT_EN
      idle_cnt <= ((state == LOAD) && !accept) ? idle_cnt + 8'd1 : 8'd0;
      if (tmo) res_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_multimac_sequencer.sv
// Scoreboard bench for multimac_sequencer with a constant stub core (core_out = 13'h0ABC).
module tb_multimac_sequencer;
`ifdef MMSEQ_TIMEOUT_EN
  localparam int LT = 4;
`else
  localparam int LT = 64;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [3:0]  req_op = 4'd0;
  logic [1:0]  req_ready;
  logic [1:0]  item_valid = 2'b00;
  logic [7:0]  item_index = 8'd0, item_data = 8'd0;
  logic [1:0]  item_last = 2'b00;
  logic [1:0]  item_ready;
  logic        res_valid, res_ready = 1'b0;
  logic [12:0] res_data;
  logic        res_id;
  logic        busy, core_rst_n, core_load, core_run;
  logic [1:0]  core_insn;
  logic [3:0]  core_index, core_data;
  logic [12:0] core_out;
`ifdef MMSEQ_TIMEOUT_EN
  logic        res_err;
`endif

  assign core_out = 13'h0ABC;
  always #5 clk = ~clk;

  multimac_sequencer #(.RUN_CYCLES(18), .LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .item_valid(item_valid), .item_index(item_index), .item_data(item_data),
    .item_last(item_last), .item_ready(item_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
`ifdef MMSEQ_TIMEOUT_EN
    .res_err(res_err),
`endif
    .busy(busy), .core_rst_n(core_rst_n), .core_insn(core_insn), .core_load(core_load),
    .core_run(core_run), .core_index(core_index), .core_data(core_data), .core_out(core_out)
  );

  int nvec = 0, nerr = 0;
  logic [14:0] sb[$];   // {err, id, data}
  logic rr_m = 1'b1;
  int load_tot = 0, run_tot = 0, crst_tot = 0, rv_tot = 0;
  logic [3:0] idx_hist [0:255];
  logic [3:0] it_idx [0:3];
  logic [3:0] it_dat [0:3];

  // Sampled mid-cycle so combinational strobes reflect the inputs driven at negedge.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (core_load) begin idx_hist[load_tot[7:0]] = core_index; load_tot++; end
      if (core_run) run_tot++;
      if (!core_rst_n) crst_tot++;
    end
    if (res_valid) rv_tot++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] mask, input logic [3:0] ops, input logic err, output int eid);
    logic [1:0] o;
    eid  = (mask == 2'b11) ? int'(!rr_m) : int'(mask[1]);
    rr_m = eid[0];
    o    = eid[0] ? ops[3:2] : ops[1:0];
    sb.push_back({err, eid[0], ((o == 2'b11) || err) ? 13'd0 : 13'h0ABC});
    req_op    = ops;
    req_valid = mask;
  endtask

  task automatic wait_grant(output int g, output int lat);
    lat = 0;
    g   = -1;
    do begin @(negedge clk); lat++; end while (req_ready == 2'b00 && lat < 50);
    if (req_ready == 2'b01) g = 0;
    else if (req_ready == 2'b10) g = 1;
    chk("grant_seen", {31'd0, g >= 0}, 1);
    if (g < 0) g = 0;
  endtask

  task automatic feed(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      while (!item_ready[r] && w < 50) begin @(negedge clk); w++; end
      chk("item_ready", {31'd0, item_ready[r]}, 1);
      item_valid[r] = 1'b1;
      item_index[4*r +: 4] = it_idx[k];
      item_data[4*r +: 4]  = it_dat[k];
      item_last[r] = (k == n - 1);
      @(negedge clk);
    end
    item_valid = 2'b00;
    item_last  = 2'b00;
  endtask

  task automatic collect(input int hold);
    int w;
    logic [14:0] e;
    w = 0;
    while (!res_valid && w < 200) begin @(negedge clk); w++; end
    chk("res_valid", {31'd0, res_valid}, 1);
    e = (sb.size() > 0) ? sb.pop_front() : 15'h7fff;
    for (int k = 0; k < hold; k++) begin
      chk("bp_valid", {31'd0, res_valid}, 1);
      chk("bp_data", {19'd0, res_data}, {19'd0, e[12:0]});
      chk("bp_id", {31'd0, res_id}, {31'd0, e[13]});
      chk("bp_no_grant", {30'd0, req_ready}, 0);
      @(negedge clk);
    end
    chk("res_data", {19'd0, res_data}, {19'd0, e[12:0]});
    chk("res_id", {31'd0, res_id}, {31'd0, e[13]});
`ifdef MMSEQ_TIMEOUT_EN
    chk("res_err", {31'd0, res_err}, {31'd0, e[14]});
`endif
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_drop", {31'd0, res_valid}, 0);
    chk("hs_no_grant", {30'd0, req_ready}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int g, lat, bl, br, bc, bv, eid, n, w;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_core_rst_n", {31'd0, core_rst_n}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_req_ready", {30'd0, req_ready}, 0);
    chk("rst_core_run", {31'd0, core_run}, 0);
    chk("rst_item_ready", {30'd0, item_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_core_rst_n", {31'd0, core_rst_n}, 1);

    // single MADD job from requester 0
    bl = load_tot; br = run_tot;
    start_job(2'b01, 4'b0010, 1'b0, eid);
    wait_grant(g, lat);
    chk("sj_grant", g, 0);
    chk("sj_latency", lat, 1);
    chk("sj_crst", {31'd0, core_rst_n}, 0);
    req_valid = 2'b00;
    @(negedge clk);
    chk("sj_pulse_end", {30'd0, req_ready}, 0);
    chk("sj_insn", {30'd0, core_insn}, 2);
    it_idx[0] = 4'd5; it_dat[0] = 4'd3; it_idx[1] = 4'd6; it_dat[1] = 4'd1;
    feed(0, 2);
    collect(0);
    chk("sj_loads", load_tot - bl, 2);
    chk("sj_idx0", {28'd0, idx_hist[8'(bl)]}, 5);
    chk("sj_idx1", {28'd0, idx_hist[8'(bl + 1)]}, 6);
    chk("sj_run_cycles", run_tot - br, 18);
    chk("sj_idle_insn", {30'd0, core_insn}, 0);

    // both requesters pending from reset: alternate 0,1,0,1; first result back-pressured
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; rr_m = 1'b1; @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      start_job(2'b11, 4'b0001, 1'b0, eid);
      wait_grant(g, lat);
      chk("arb_grant", g, eid);
      chk("arb_alternate", g, j % 2);
      it_idx[0] = 4'(j); it_dat[0] = 4'(j + 1);
      feed(g, 1);
      collect((j == 0) ? 10 : 0);
    end
    req_valid = 2'b00;

    // invalid opcode: no core activity at all
    bl = load_tot; br = run_tot; bc = crst_tot;
    start_job(2'b10, 4'b1100, 1'b0, eid);
    wait_grant(g, lat);
    chk("inv_grant", g, 1);
    req_valid = 2'b00;
    collect(0);
    chk("inv_loads", load_tot - bl, 0);
    chk("inv_runs", run_tot - br, 0);
    chk("inv_crst", crst_tot - bc, 0);

    // reset during RUN aborts silently
    start_job(2'b01, 4'b0000, 1'b0, eid);
    void'(sb.pop_back());
    wait_grant(g, lat);
    req_valid = 2'b00;
    it_idx[0] = 4'd2; it_dat[0] = 4'd7;
    feed(0, 1);
    n = 0; w = 0;
    while (n < 7 && w < 100) begin
      if (core_run) n++;
      if (n < 7) @(negedge clk);
      w++;
    end
    chk("mr_run_reached", n, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_core_rst_n", {31'd0, core_rst_n}, 0);
    chk("mr_res_valid", {31'd0, res_valid}, 0);
    chk("mr_core_run", {31'd0, core_run}, 0);
    bv = rv_tot;
    rst_n = 1'b1; rr_m = 1'b1;
    repeat (30) @(negedge clk);
    chk("mr_no_result", rv_tot - bv, 0);

`ifdef MMSEQ_TIMEOUT_EN
    // no items: abort after LOAD_TIMEOUT idle LOAD cycles
    start_job(2'b01, 4'b0010, 1'b1, eid);
    wait_grant(g, lat);
    req_valid = 2'b00;
    w = 0;
    while (!res_valid && w < 50) begin @(negedge clk); w++; end
    chk("tmo_latency", w, 6);
    collect(0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
